// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// active-low hex glyph table, blank pattern and slot-divider sizing.
package seg_display_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index is the nibble value; bit order is {g,f,e,d,c,b,a}, low = segment on.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic int calc_div(input int clk_hz, input int refresh_hz);
      return clk_hz / refresh_hz;
   endfunction

   function automatic int calc_slot_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
   import seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment scan driver with frame snapshot, per-digit enable,
// PWM dimming, ghost blanking and frame strobe. Optional: LEADING_ZERO_BLANK_EN.
module seg_display_scan
   import seg_display_pkg::*;
#(
   parameter int DIGITS     = 8,
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int BLANK_CYC  = 16,
   parameter int BR_W       = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_value,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic [BR_W-1:0]       brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int DIV    = calc_div(CLK_HZ, REFRESH_HZ);
   localparam int SLOT_W = calc_slot_w(DIV);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [SLOT_W-1:0]   slot_cnt;
   logic [IDX_W-1:0]    idx;
   logic [BR_W-1:0]     pwm_cnt;
   logic                slot_end;
   logic                frame_end;

   logic [4*DIGITS-1:0] sh_value;
   logic [DIGITS-1:0]   sh_dp;
   logic [DIGITS-1:0]   sh_en;
   logic [DIGITS-1:0]   snap_en;

   logic [3:0]          cur_nib;
   logic [6:0]          dec_seg;
   logic [DIGITS-1:0]   onehot;
   logic                br_full;
   logic                lit;

   assign slot_end  = (slot_cnt == SLOT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt <= '0;
         idx      <= '0;
         pwm_cnt  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (slot_end) begin
            slot_cnt <= '0;
            idx      <= frame_end ? '0 : idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic leading;

   // Walk down from the top digit; digits above the first nonzero nibble go dark.
   always_comb begin
      snap_en = digit_en;
      leading = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (value[4*i +: 4] != 4'h0) leading = 1'b0;
         if (leading) snap_en[i] = 1'b0;
      end
   end
`else
   assign snap_en = digit_en;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_value <= '0;
         sh_dp    <= '0;
         sh_en    <= '0;
      end else if (frame_end) begin
         sh_value <= value;
         sh_dp    <= dp_value;
         sh_en    <= snap_en;
      end
   end

   assign cur_nib = sh_value[4*idx +: 4];

   hex_to_seg7 u_dec (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

   // All-ones brightness must cover the pwm_cnt value that "<" would miss.
   assign br_full = &brightness;
   assign lit     = sh_en[idx] && (slot_cnt >= BLANK_END) &&
                    (br_full || (pwm_cnt < brightness));

   // Output register stage: pins follow counter/shadow state one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an         <= '1;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (lit) begin
            an  <= ~onehot;
            seg <= dec_seg;
            dp  <= ~sh_dp[idx];
         end else begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
         end
      end
   end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Parametrised multiplexed seven-segment scan driver and successor to the fixed 8-digit display driver. It time-multiplexes DIGITS hex nibbles onto shared active-low cathodes and per-digit active-low anodes. Beyond the fixed driver, it adds:
- tear-free frame snapshotting,
- per-digit enable,
- PWM brightness,
- inter-digit ghost blanking,
- a frame-done strobe.

It sits between the board top level (debug register/PC display) and the AN/CA..CG/DP pins.

## Interface
Parameters:
- DIGITS, 8: number of digits scanned, 1..16.
- CLK_HZ, 100_000_000: clk frequency in Hz.
- REFRESH_HZ, 1000: digit-slot rate in Hz. DIV = CLK_HZ/REFRESH_HZ cycles per slot. DIV must be at least BLANK_CYC+2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off.
- BR_W, 4: brightness field width.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- value, input, 4*DIGITS: hex nibbles. Nibble i (bits 4i+3:4i) maps to digit i.
- dp_value, input, DIGITS: decimal point per digit, 1 = lit.
- digit_en, input, DIGITS: 0 = digit i always dark.
- brightness, input, BR_W: 0 = off; all-ones = full on.
- seg, output, 7: cathodes {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal-point cathode, active-low.
- an, output, DIGITS: anodes, active-low.
- frame_done, output, 1: one-cycle pulse when the scan wraps.

## Operation
- Slot counter slot_cnt runs 0..DIV-1. Digit index idx advances on slot_cnt==DIV-1 and wraps from DIGITS-1 to 0.
- Frame boundary is the cycle where idx wraps DIGITS-1→0. On that cycle:
  - value, dp_value and digit_en are copied into shadow registers;
  - frame_done is asserted for exactly that cycle.
- All decoding uses the shadow registers only. Input changes mid-frame never appear until the next frame.
- PWM: pwm_cnt is a free-running BR_W-bit counter that wraps.
- Digit lit condition: idx's shadow enable = 1 AND slot_cnt ≥ BLANK_CYC AND (brightness == all-ones OR pwm_cnt < brightness).
- When lit:
  - an = ~(1<<idx);
  - seg = hex decode of shadow nibble idx;
  - dp = ~shadow dp bit.
- When not lit: an, seg and dp are all ones.
- Hex decode (active-low, g..a):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78;
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- brightness is sampled live, not shadowed.
- Reset (async assert, synchronous release by clk):
  - slot_cnt, idx, pwm_cnt and shadows cleared to 0;
  - an, seg and dp all ones;
  - frame_done = 0.
- Reset mid-slot aborts the scan. The first slot after release is digit 0, with a full BLANK_CYC blank.
- Shadows stay 0 until the first frame boundary, so the first frame is dark (shadow enables are 0).

## Timing
- All outputs are registered: pins reflect counter state one cycle later.
- Slot length is DIV cycles. Frame length is DIGITS*DIV cycles. frame_done period is DIGITS*DIV.
- First frame_done occurs DIGITS*DIV cycles after reset release. The shadows are valid from the cycle after it.
- An input change reaches the pins at most 2*DIGITS*DIV+1 cycles later.
- Anode transitions are separated by at least BLANK_CYC all-off cycles. Two anodes are never low simultaneously.

## Configuration
- LEADING_ZERO_BLANK_EN defined: at snapshot, every digit above the most significant nonzero nibble has its shadow enable forced to 0. Digit 0 is never blanked by this rule, and its dp is still shown if enabled.
- LEADING_ZERO_BLANK_EN undefined: all digits are governed only by digit_en.

## Structure
- Package seg_display_pkg holds:
  - the 16-entry hex-to-segment constant table and the SEG_OFF constant (7'h7F);
  - the function computing DIV and the slot_cnt width with $clog2.
- Sub-module hex_to_seg7: combinational nibble→7-bit active-low decoder using the package table.
- Counters, shadows, PWM and output registers live in seg_display_scan.

## Test plan
Unless noted, bench parameters are DIGITS=4, CLK_HZ=64, REFRESH_HZ=4 (DIV=16), BLANK_CYC=2, BR_W=4.

- Reset/first frame: release reset with value=16'h1234, digit_en=4'hF, brightness=4'hF.
  - an stays 4'hF through frame 0.
  - frame_done pulses at cycle 64.
  - Digit 0 then shows seg=7'h19 ("4") with an=4'b1110 after the 2 blank cycles.
- Scan order/blanking: over one frame, an sequence is 1110, 1101, 1011, 0111.
  - Each slot has 2 all-ones cycles then 14 lit cycles.
  - seg values are 7'h19, 7'h30, 7'h24, 7'h79.
- Snapshot: change value to 16'hFFFF mid-frame. Current-frame seg is unchanged; next frame all digits show 7'h0E.
- Brightness: brightness=4 → each slot's lit cycles equal the post-blank cycles with pwm_cnt<4. brightness=0 → an constant 4'hF.
- Async reset mid-slot: assert reset between clock edges during digit 2.
  - an/seg/dp go all-ones immediately.
  - After release, digit 0 is scanned first.
- With LEADING_ZERO_BLANK_EN: value=16'h0005 → only digit 0 is lit (7'h12). value=16'h0000 → digit 0 shows 7'h40.
